// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the ID/EX stage: ALU selects, aluOp encodings,
// forward-select enum and the ALU control decode used at the decode slot.
package riscv_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [1:0] sel;
        logic       illegal;
    } alu_dec_t;

    function automatic alu_dec_t decode_alu(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic       funct7b5,
        input logic       alu_src
    );
        alu_dec_t d;
        d.sel     = ALU_ADD;
        d.illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: d.sel = ALU_ADD;
            ALUOP_SUB: d.sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register forms may subtract; addi with bit 30 set is still add.
                    F3_ADDSUB: d.sel = (funct7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
                    F3_AND:    d.sel = ALU_AND;
                    F3_OR:     d.sel = ALU_OR;
                    default:   d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass for one source register: EX/MEM result beats MEM/WB result,
// which beats the registered register-file data; x0 is never bypassed.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      src_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic [4:0]      ex_mem_rd,
    input  logic            ex_mem_reg_write,
    input  logic [XLEN-1:0] ex_mem_result,
    input  logic [4:0]      mem_wb_rd,
    input  logic            mem_wb_reg_write,
    input  logic [XLEN-1:0] mem_wb_result,
    output logic [XLEN-1:0] fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel = FWD_REG;
        if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == src_addr))
            sel = FWD_EXMEM;
        else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == src_addr))
            sel = FWD_MEMWB;
    end

    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXMEM: fwd_data = ex_mem_result;
            FWD_MEMWB: fwd_data = mem_wb_result;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and operand selection.
// Define FORWARDING_EN to bypass EX/MEM and MEM/WB results into the operands.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1Addr,
    input  logic [4:0]      rs2Addr,
    input  logic [4:0]      rdAddr,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [1:0]      aluOp,
    input  logic            aluSrc,
    input  logic            regWrite,
    input  logic [4:0]      exMemRd,
    input  logic [4:0]      memWbRd,
    input  logic            exMemRegWrite,
    input  logic            memWbRegWrite,
    input  logic [XLEN-1:0] exMemResult,
    input  logic [XLEN-1:0] memWbResult,
    output logic [XLEN-1:0] aluA,
    output logic [XLEN-1:0] aluB,
    output logic [1:0]      aluSel,
    output logic [XLEN-1:0] exRs2Data,
    output logic [4:0]      exRd,
    output logic            exRegWrite,
    output logic            outValid,
    output logic            illegal
);

    alu_dec_t        dec;
    logic            valid_q;
    logic            reg_write_q;
    logic            illegal_q;
    logic [1:0]      alu_sel_q;
    logic            alu_src_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_addr_q;
    logic [4:0]      rs2_addr_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    always_comb dec = decode_alu(aluOp, funct3, funct7b5, aluSrc);

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_sel_q   <= ALU_ADD;
            alu_src_q   <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
        end else if (flush) begin
            // A killed slot only needs its side-effecting bits cleared.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (!stall) begin
            valid_q     <= inValid;
            reg_write_q <= regWrite & inValid;
            illegal_q   <= dec.illegal & inValid;
            alu_sel_q   <= dec.sel;
            alu_src_q   <= aluSrc;
            rs1_data_q  <= rs1Data;
            rs2_data_q  <= rs2Data;
            imm_q       <= imm;
            rs1_addr_q  <= rs1Addr;
            rs2_addr_q  <= rs2Addr;
            rd_q        <= rdAddr;
        end
    end

`ifdef FORWARDING_EN
    forward_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_addr        (rs1_addr_q),
        .reg_data        (rs1_data_q),
        .ex_mem_rd       (exMemRd),
        .ex_mem_reg_write(exMemRegWrite),
        .ex_mem_result   (exMemResult),
        .mem_wb_rd       (memWbRd),
        .mem_wb_reg_write(memWbRegWrite),
        .mem_wb_result   (memWbResult),
        .fwd_data        (rs1_fwd)
    );

    forward_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_addr        (rs2_addr_q),
        .reg_data        (rs2_data_q),
        .ex_mem_rd       (exMemRd),
        .ex_mem_reg_write(exMemRegWrite),
        .ex_mem_result   (exMemResult),
        .mem_wb_rd       (memWbRd),
        .mem_wb_reg_write(memWbRegWrite),
        .mem_wb_result   (memWbResult),
        .fwd_data        (rs2_fwd)
    );
`else
    assign rs1_fwd = rs1_data_q;
    assign rs2_fwd = rs2_data_q;

    // Bypass ports stay on the boundary so both builds share one interface.
    logic unused_fwd;
    assign unused_fwd = ^{exMemRd, memWbRd, exMemRegWrite, memWbRegWrite,
                          exMemResult, memWbResult, rs1_addr_q, rs2_addr_q};
`endif

    assign aluA       = rs1_fwd;
    assign aluB       = alu_src_q ? imm_q : rs2_fwd;
    assign exRs2Data  = rs2_fwd;
    assign aluSel     = alu_sel_q;
    assign exRd       = rd_q;
    assign exRegWrite = reg_write_q;
    assign outValid   = valid_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expected forwarding results depend on FORWARDING_EN.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic            regw;
        logic            ill;
        logic [1:0]      sel;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] s;
        logic [4:0]      rd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            inValid = 0, stall = 0, flush = 0;
    logic [XLEN-1:0] rs1Data = '0, rs2Data = '0, imm = '0;
    logic [4:0]      rs1Addr = '0, rs2Addr = '0, rdAddr = '0;
    logic [2:0]      funct3 = '0;
    logic            funct7b5 = 0, aluSrc = 0, regWrite = 0;
    logic [1:0]      aluOp = '0;
    logic [4:0]      exMemRd = '0, memWbRd = '0;
    logic            exMemRegWrite = 0, memWbRegWrite = 0;
    logic [XLEN-1:0] exMemResult = '0, memWbResult = '0;
    logic [XLEN-1:0] aluA, aluB, exRs2Data;
    logic [1:0]      aluSel;
    logic [4:0]      exRd;
    logic            exRegWrite, outValid, illegal;

    exp_t obs;
    exp_t sb[$];
    exp_t e;
    exp_t last_exp;
    int   vectors = 0;
    int   miscompares = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .stall(stall), .flush(flush),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr),
        .funct3(funct3), .funct7b5(funct7b5), .aluOp(aluOp), .aluSrc(aluSrc),
        .regWrite(regWrite), .exMemRd(exMemRd), .memWbRd(memWbRd),
        .exMemRegWrite(exMemRegWrite), .memWbRegWrite(memWbRegWrite),
        .exMemResult(exMemResult), .memWbResult(memWbResult),
        .aluA(aluA), .aluB(aluB), .aluSel(aluSel), .exRs2Data(exRs2Data),
        .exRd(exRd), .exRegWrite(exRegWrite), .outValid(outValid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {outValid, exRegWrite, illegal, aluSel, aluA, aluB, exRs2Data, exRd};

    // Independent reference for the ALU control table.
    function automatic exp_t model(input logic v, input logic rw, input logic [1:0] op,
                                   input logic [2:0] f3, input logic f7, input logic src,
                                   input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                                   input logic [XLEN-1:0] im, input logic [4:0] rd);
        exp_t x;
        logic [1:0] s;
        logic il;
        il = 1'b0;
        s  = 2'b00;
        if (op == 2'b01) s = 2'b01;
        else if (op == 2'b11) il = 1'b1;
        else if (op == 2'b10) begin
            if (f3 == 3'b000) s = (f7 && !src) ? 2'b01 : 2'b00;
            else if (f3 == 3'b111) s = 2'b10;
            else if (f3 == 3'b110) s = 2'b11;
            else il = 1'b1;
        end
        x.valid = v;
        x.regw  = rw & v;
        x.ill   = il & v;
        x.sel   = s;
        x.a     = r1;
        x.b     = src ? im : r2;
        x.s     = r2;
        x.rd    = rd;
        return x;
    endfunction

    task automatic drive_slot(input logic v, input logic rw, input logic [1:0] op,
                              input logic [2:0] f3, input logic f7, input logic src,
                              input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                              input logic [XLEN-1:0] im, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] rd);
        inValid = v; regWrite = rw; aluOp = op; funct3 = f3; funct7b5 = f7; aluSrc = src;
        rs1Data = r1; rs2Data = r2; imm = im; rs1Addr = a1; rs2Addr = a2; rdAddr = rd;
        last_exp = model(v, rw, op, f3, f7, src, r1, r2, im, rd);
        sb.push_back(last_exp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== '0) begin
            $display("FAIL reset_state got=%h exp=0", obs);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [1:0] ops[6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
        logic [2:0] f3s[6] = '{3'b000, 3'b101, 3'b000, 3'b111, 3'b111, 3'b110};
        logic       f7s[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_slot(1'b1, 1'b1, ops[i], f3s[i], f7s[i], 1'b0,
                       (i == 0) ? 32'd10 : 32'h100 + i, (i == 0) ? 32'd3 : 32'h200 + i,
                       32'h55, 5'd1, 5'd2, 5'(i + 3));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                $display("FAIL decode[%0d] got=%h exp=%h", i, obs, e);
                miscompares++;
            end
        end
        // funct7b5 with an immediate operand is still an add
        @(negedge clk);
        drive_slot(1'b1, 1'b0, 2'b10, 3'b000, 1'b1, 1'b1, 32'd7, 32'd9, 32'd4, 5'd1, 5'd2, 5'd8);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL decode_addi got=%h exp=%h", obs, e);
            miscompares++;
        end
    endtask

    task automatic test_imm_illegal();
        @(negedge clk);
        drive_slot(1'b1, 1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFC,
                   5'd1, 5'd2, 5'd9);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e || aluB !== 32'hFFFF_FFFC || illegal !== 1'b1) begin
            $display("FAIL imm_illegal got=%h exp=%h", obs, e);
            miscompares++;
        end
        // illegal is masked for an invalid slot
        @(negedge clk);
        drive_slot(1'b0, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd9);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL illegal_masked got=%h exp=%h", obs, e);
            miscompares++;
        end
    endtask

    task automatic test_forwarding();
        logic [XLEN-1:0] exp_ex, exp_wb, exp_rs2;
`ifdef FORWARDING_EN
        exp_ex = 32'hAA; exp_wb = 32'hBB; exp_rs2 = 32'hAA;
`else
        exp_ex = 32'h11; exp_wb = 32'h11; exp_rs2 = 32'h33;
`endif
        @(negedge clk);
        drive_slot(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'h11, 32'h33, 32'h0,
                   5'd5, 5'd5, 5'd4);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL fwd_idle got=%h exp=%h", obs, e);
            miscompares++;
        end
        exMemRd = 5'd5; exMemResult = 32'hAA; exMemRegWrite = 1'b1;
        memWbRd = 5'd5; memWbResult = 32'hBB; memWbRegWrite = 1'b1;
        #1;
        vectors++;
        if (aluA !== exp_ex || exRs2Data !== exp_rs2) begin
            $display("FAIL fwd_exmem_prio aluA=%h exp=%h rs2=%h exp=%h", aluA, exp_ex, exRs2Data, exp_rs2);
            miscompares++;
        end
        exMemRegWrite = 1'b0;
        #1;
        vectors++;
        if (aluA !== exp_wb) begin
            $display("FAIL fwd_memwb aluA=%h exp=%h", aluA, exp_wb);
            miscompares++;
        end
        exMemRegWrite = 1'b1;
        @(negedge clk);
        exMemRd = 5'd0; memWbRd = 5'd0;
        drive_slot(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'h22, 32'h44, 32'h0,
                   5'd0, 5'd0, 5'd4);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e || aluA !== 32'h22) begin
            $display("FAIL fwd_x0 got=%h exp=%h", obs, e);
            miscompares++;
        end
        @(negedge clk);
        exMemRegWrite = 1'b0; memWbRegWrite = 1'b0;
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        drive_slot(1'b1, 1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'h0,
                   5'd6, 5'd7, 5'd10);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL stall_load got=%h exp=%h", obs, e);
            miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            inValid = 1'b0; regWrite = 1'b0; aluOp = 2'(i); rs1Data = $urandom;
            rs2Data = $urandom; rdAddr = 5'(i + 20);
            sb.push_back(last_exp);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, e);
                miscompares++;
            end
        end
        @(negedge clk);
        flush = 1'b1; inValid = 1'b1; regWrite = 1'b1; aluOp = 2'b11;
        @(posedge clk);
        #1;
        vectors++;
        if ({outValid, exRegWrite, illegal} !== 3'b000) begin
            $display("FAIL stall_flush got=%b exp=000", {outValid, exRegWrite, illegal});
            miscompares++;
        end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_slot(1'b1, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h5678, 32'h0,
                   5'd1, 5'd2, 5'd3);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL prereset_load got=%h exp=%h", obs, e);
            miscompares++;
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (outValid !== 1'b0 || aluA !== '0 || aluSel !== 2'b00) begin
            $display("FAIL async_reset v=%b a=%h sel=%b exp=0", outValid, aluA, aluSel);
            miscompares++;
        end
        rst = 1'b0;
        // reset while stalled drops the held slot; the first edge after loads normally
        @(negedge clk);
        drive_slot(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'hAB, 32'hCD, 32'h0,
                   5'd1, 5'd2, 5'd11);
        stall = 1'b1;
        void'(sb.pop_front());
        sb.push_back('0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL reset_in_stall got=%h exp=%h", obs, e);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        drive_slot(1'b1, 1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 32'hAB, 32'hCD, 32'h0,
                   5'd1, 5'd2, 5'd11);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            $display("FAIL post_reset_load got=%h exp=%h", obs, e);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_slot(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom),
                       1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                       5'($urandom), 5'($urandom));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, e);
                miscompares++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_decode();
        test_imm_illegal();
        test_forwarding();
        test_stall_flush();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
